// File: rtl/dp_pkg.sv
// Shared encodings for the datapath controller: command opcodes, FSM states
// and the ALU function codes understood by the attached datapath.
package dp_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef enum logic [1:0] {
        OP_LOADI = 2'b00,
        OP_ALU   = 2'b01,
        OP_READ  = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_WB   = 2'b10,
        S_RESP = 2'b11
    } state_t;

    typedef enum logic [2:0] {
        ALUC_ADD = 3'b000,
        ALUC_SUB = 3'b001,
        ALUC_OR  = 3'b010,
        ALUC_AND = 3'b011
    } aluc_t;

endpackage

// File: rtl/dp_ctrl.sv
// Command sequencer for the regfile+ALU datapath: accepts one command at a
// time, drives the datapath through EXEC/WB, and returns a result.
module dp_ctrl
    import dp_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    input  logic [1:0]          cmd_op,
    input  logic [2:0]          cmd_aluc,
    input  logic [ADDR_W-1:0]   cmd_ra,
    input  logic [ADDR_W-1:0]   cmd_rb,
    input  logic [ADDR_W-1:0]   cmd_rw,
    input  logic [DATA_W-1:0]   cmd_imm,
    output logic                cmd_ready,
    output logic                we,
    output logic                mux3,
    output logic [2:0]          aluc,
    output logic [ADDR_W-1:0]   ra,
    output logic [ADDR_W-1:0]   rb,
    output logic [ADDR_W-1:0]   rw,
    output logic [DATA_W-1:0]   rd,
    input  logic [DATA_W-1:0]   qa,
    input  logic [DATA_W-1:0]   qb,
    input  logic [DATA_W-1:0]   alu_out,
    input  logic                zero,
    output logic                res_valid,
    output logic [DATA_W-1:0]   res_data,
    output logic                res_zero,
    input  logic                res_ready,
    output logic [1:0]          o_dbg_state
);

    // Handshakes: a command transfers on a rising edge where cmd_valid && cmd_ready,
    // a result transfers on a rising edge where res_valid && res_ready; res_valid,
    // res_data and res_zero stay stable from assertion until that transfer edge.

    state_t              r_state;
    state_t              w_next_state;
    op_t                 r_op;
    op_t                 w_op_nxt;
    logic                r_we;
    logic                w_we_nxt;
    logic                r_mux3;
    logic                w_mux3_nxt;
    logic [2:0]          r_aluc;
    logic [2:0]          w_aluc_nxt;
    logic [ADDR_W-1:0]   r_ra;
    logic [ADDR_W-1:0]   w_ra_nxt;
    logic [ADDR_W-1:0]   r_rb;
    logic [ADDR_W-1:0]   w_rb_nxt;
    logic [ADDR_W-1:0]   r_rw;
    logic [ADDR_W-1:0]   w_rw_nxt;
    logic [DATA_W-1:0]   r_rd;
    logic [DATA_W-1:0]   w_rd_nxt;
    logic                r_res_valid;
    logic                w_res_valid_nxt;
    logic [DATA_W-1:0]   r_res_data;
    logic [DATA_W-1:0]   w_res_data_nxt;
    logic                r_res_zero;
    logic                w_res_zero_nxt;

    // Operand B is consumed by the ALU only; the controller never looks at it.
    logic                w_unused_qb;
    assign w_unused_qb = ^qb;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= OP_LOADI;
            r_we        <= 1'b0;
            r_mux3      <= 1'b0;
            r_aluc      <= '0;
            r_ra        <= '0;
            r_rb        <= '0;
            r_rw        <= '0;
            r_rd        <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_zero  <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_op        <= w_op_nxt;
            r_we        <= w_we_nxt;
            r_mux3      <= w_mux3_nxt;
            r_aluc      <= w_aluc_nxt;
            r_ra        <= w_ra_nxt;
            r_rb        <= w_rb_nxt;
            r_rw        <= w_rw_nxt;
            r_rd        <= w_rd_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_res_data  <= w_res_data_nxt;
            r_res_zero  <= w_res_zero_nxt;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_op_nxt        = r_op;
        w_we_nxt        = 1'b0;
        w_mux3_nxt      = r_mux3;
        w_aluc_nxt      = r_aluc;
        w_ra_nxt        = r_ra;
        w_rb_nxt        = r_rb;
        w_rw_nxt        = r_rw;
        w_rd_nxt        = r_rd;
        w_res_valid_nxt = r_res_valid;
        w_res_data_nxt  = r_res_data;
        w_res_zero_nxt  = r_res_zero;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_op_nxt = op_t'(cmd_op);
                    case (op_t'(cmd_op))
                        OP_LOADI: begin
                            w_next_state   = S_WB;
                            w_rw_nxt       = cmd_rw;
                            w_rd_nxt       = cmd_imm;
                            w_mux3_nxt     = 1'b0;
                            w_we_nxt       = (cmd_rw != '0);
                            w_res_data_nxt = cmd_imm;
                            w_res_zero_nxt = (cmd_imm == '0);
                        end
                        OP_ALU: begin
                            w_next_state = S_EXEC;
                            w_ra_nxt     = cmd_ra;
                            w_rb_nxt     = cmd_rb;
                            w_aluc_nxt   = cmd_aluc;
                            w_rw_nxt     = cmd_rw;
                        end
                        OP_READ: begin
                            w_next_state = S_EXEC;
                            w_ra_nxt     = cmd_ra;
                        end
                        default: begin
                            w_next_state    = S_RESP;
                            w_res_valid_nxt = 1'b1;
                            w_res_data_nxt  = '0;
                            w_res_zero_nxt  = 1'b1;
                        end
                    endcase
                end
            end
            S_EXEC: begin
                if (r_op == OP_ALU) begin
                    w_next_state   = S_WB;
                    w_we_nxt       = (r_rw != '0);
                    w_mux3_nxt     = 1'b1;
                    w_res_data_nxt = alu_out;
                    w_res_zero_nxt = zero;
                end else begin
                    w_next_state    = S_RESP;
                    w_res_valid_nxt = 1'b1;
                    w_res_data_nxt  = qa;
                    w_res_zero_nxt  = (qa == '0);
                end
            end
            S_WB: begin
                w_next_state    = S_RESP;
                w_res_valid_nxt = 1'b1;
            end
            S_RESP: begin
                if (res_ready) begin
                    w_next_state    = S_IDLE;
                    w_res_valid_nxt = 1'b0;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // we is gated by rst_n so a reset landing on WB blocks the regfile write at that same edge.
    assign we          = r_we & rst_n;
    assign cmd_ready   = (r_state == S_IDLE) & rst_n;
    assign mux3        = r_mux3;
    assign aluc        = r_aluc;
    assign ra          = r_ra;
    assign rb          = r_rb;
    assign rw          = r_rw;
    assign rd          = r_rd;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_zero    = r_res_zero;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dp_ctrl.sv
// Bench for dp_ctrl: a regfile+ALU environment, a command-level result model
// with an expected queue, and directed command sequences with literal results.
module tb_dp_ctrl;
    import dp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_aluc;
    logic [4:0]  cmd_ra, cmd_rb, cmd_rw;
    logic [31:0] cmd_imm;
    logic        cmd_ready;
    logic        we, mux3;
    logic [2:0]  aluc;
    logic [4:0]  ra, rb, rw;
    logic [31:0] rd, qa, qb, alu_out;
    logic        zero;
    logic        res_valid, res_zero, res_ready;
    logic [31:0] res_data;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    logic [32:0] exp_q[$];
    logic [31:0] regs [32] = '{default: 32'h0};
    logic [31:0] mdl_regs [32] = '{default: 32'h0};

    always #5 clk = ~clk;

    dp_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_aluc(cmd_aluc),
        .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rw(cmd_rw), .cmd_imm(cmd_imm),
        .cmd_ready(cmd_ready),
        .we(we), .mux3(mux3), .aluc(aluc), .ra(ra), .rb(rb), .rw(rw), .rd(rd),
        .qa(qa), .qb(qb), .alu_out(alu_out), .zero(zero),
        .res_valid(res_valid), .res_data(res_data), .res_zero(res_zero),
        .res_ready(res_ready), .o_dbg_state(dbg_state)
    );

    function automatic logic [31:0] alu_f(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a | b;
            3'd3:    return a & b;
            default: return 32'h0;
        endcase
    endfunction

    // Datapath environment: R0 reads zero, write lands on the rising edge.
    assign qa      = (ra == 5'd0) ? 32'h0 : regs[ra];
    assign qb      = (rb == 5'd0) ? 32'h0 : regs[rb];
    assign alu_out = alu_f(aluc, qa, qb);
    assign zero    = (alu_out == 32'h0);

    always @(posedge clk) begin
        if (we && rw != 5'd0) regs[rw] <= mux3 ? alu_out : rd;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Command-level model: the result each command must return, and its register effect.
    task automatic push_exp(input logic [1:0] op, input logic [2:0] ac, input logic [4:0] a,
                            input logic [4:0] b, input logic [4:0] w, input logic [31:0] imm);
        logic [31:0] va, vb, r;
        va = (a == 5'd0) ? 32'h0 : mdl_regs[a];
        vb = (b == 5'd0) ? 32'h0 : mdl_regs[b];
        case (op)
            2'b00:   r = imm;
            2'b01:   r = alu_f(ac, va, vb);
            2'b10:   r = va;
            default: r = 32'h0;
        endcase
        exp_q.push_back({(r == 32'h0), r});
        if ((op == 2'b00 || op == 2'b01) && w != 5'd0) mdl_regs[w] = r;
    endtask

    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n && res_valid) begin
            chk("cmd_ready_in_resp", {31'h0, cmd_ready}, 32'h0);
            chk("we_in_resp", {31'h0, we}, 32'h0);
            if (res_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got=%h expected=none", res_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("model_res_data", res_data, e[31:0]);
                    chk("model_res_zero", {31'h0, res_zero}, {31'h0, e[32]});
                end
            end
        end
    end

    task automatic drive_cmd(input logic [1:0] op, input logic [2:0] ac, input logic [4:0] a,
                             input logic [4:0] b, input logic [4:0] w, input logic [31:0] imm);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_aluc  = ac;
        cmd_ra    = a;
        cmd_rb    = b;
        cmd_rw    = w;
        cmd_imm   = imm;
    endtask

    task automatic wait_accept(input string name);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk({name, "_accept_timeout"}, 32'h0, 32'h1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Issues one command with res_ready high; checks latency, write pulse and literal result.
    task automatic run_cmd(input string name, input logic [1:0] op, input logic [2:0] ac,
                           input logic [4:0] a, input logic [4:0] b, input logic [4:0] w,
                           input logic [31:0] imm, input logic [31:0] exp_d, input logic exp_z,
                           input int exp_lat, input int exp_we, input logic exp_mux);
        int lat = 0, we_cnt = 0, we_lat = 0;
        logic [4:0] we_rw;
        logic [31:0] we_rd;
        logic we_mux;
        we_rw = 5'd0; we_rd = 32'h0; we_mux = 1'b0;
        @(posedge clk);
        #1;
        push_exp(op, ac, a, b, w, imm);
        drive_cmd(op, ac, a, b, w, imm);
        wait_accept(name);
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (we) begin
                we_cnt++;
                we_lat = lat;
                we_rw  = rw;
                we_rd  = rd;
                we_mux = mux3;
            end
            if (res_valid) break;
        end
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_res_data"}, res_data, exp_d);
        chk({name, "_res_zero"}, {31'h0, res_zero}, {31'h0, exp_z});
        chk({name, "_we_pulses"}, we_cnt, exp_we);
        if (exp_we == 1 && we_cnt == 1) begin
            chk({name, "_we_rw"}, {27'h0, we_rw}, {27'h0, w});
            chk({name, "_we_mux3"}, {31'h0, we_mux}, {31'h0, exp_mux});
            chk({name, "_we_cycle"}, we_lat, exp_lat - 1);
            if (op == 2'b00) chk({name, "_we_rd"}, we_rd, imm);
        end
    endtask

    initial begin
        logic [31:0] held;
        int n;
        int we_cnt;
        rst_n = 1'b0; res_ready = 1'b1;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_aluc = 3'd0;
        cmd_ra = 5'd0; cmd_rb = 5'd0; cmd_rw = 5'd0; cmd_imm = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        chk("rst_we", {31'h0, we}, 32'h0);
        chk("rst_outputs", {mux3, aluc, ra, rb, rw, res_valid, res_zero}, 32'h0);
        chk("rst_rd", rd, 32'h0);
        chk("rst_res_data", res_data, 32'h0);
        chk("rst_state", {30'h0, dbg_state}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", {31'h0, cmd_ready}, 32'h1);

        //        name          op     aluc  ra  rb  rw  imm           exp_d         z  lat we mux
        run_cmd("loadi_r4",  2'b00, 3'd0, 0,  0,  4,  32'h4,        32'h4,        0, 2, 1, 0);
        run_cmd("loadi_r5",  2'b00, 3'd0, 0,  0,  5,  32'h5,        32'h5,        0, 2, 1, 0);
        run_cmd("add_r6",    2'b01, 3'd0, 4,  5,  6,  32'h0,        32'h9,        0, 3, 1, 1);
        run_cmd("sub_r7",    2'b01, 3'd1, 4,  5,  7,  32'h0,        32'hFFFFFFFF, 0, 3, 1, 1);
        run_cmd("and_r9",    2'b01, 3'd3, 4,  5,  9,  32'h0,        32'h4,        0, 3, 1, 1);
        run_cmd("or_r8",     2'b01, 3'd2, 4,  5,  8,  32'h0,        32'h5,        0, 3, 1, 1);
        run_cmd("read_r6",   2'b10, 3'd0, 6,  0,  0,  32'h0,        32'h9,        0, 2, 0, 0);
        run_cmd("sub_r10",   2'b01, 3'd1, 4,  4,  10, 32'h0,        32'h0,        1, 3, 1, 1);
        run_cmd("add_rw0",   2'b01, 3'd0, 4,  5,  0,  32'h0,        32'h9,        0, 3, 0, 0);
        run_cmd("read_r10",  2'b10, 3'd0, 10, 0,  0,  32'h0,        32'h0,        1, 2, 0, 0);
        run_cmd("read_r7",   2'b10, 3'd0, 7,  0,  0,  32'h0,        32'hFFFFFFFF, 0, 2, 0, 0);
        run_cmd("reserved",  2'b11, 3'd0, 3,  3,  3,  32'hABCD,     32'h0,        1, 1, 0, 0);
        run_cmd("loadi_r0",  2'b00, 3'd0, 0,  0,  0,  32'h1234,     32'h1234,     0, 2, 0, 0);

        // Backpressure: result held for 5 cycles while a LOADI waits on cmd_valid.
        @(posedge clk);
        #1 res_ready = 1'b0;
        push_exp(2'b10, 3'd0, 5, 0, 0, 32'h0);
        drive_cmd(2'b10, 3'd0, 5, 0, 0, 32'h0);
        wait_accept("bp_read");
        drive_cmd(2'b00, 3'd0, 0, 0, 11, 32'h80000000);
        n = 0;
        @(negedge clk);
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        held = res_data;
        chk("bp_first_data", held, 32'h5);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_valid_held", {31'h0, res_valid}, 32'h1);
            chk("bp_data_stable", res_data, held);
            chk("bp_cmd_ready_low", {31'h0, cmd_ready}, 32'h0);
            chk("bp_state_resp", {30'h0, dbg_state}, 32'h3);
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        push_exp(2'b00, 3'd0, 0, 0, 11, 32'h80000000);
        wait_accept("bp_pending");
        n = 0; we_cnt = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (we) we_cnt++;
            if (res_valid) break;
        end
        chk("bp_pending_latency", n, 2);
        chk("bp_pending_data", res_data, 32'h80000000);
        chk("bp_pending_we_once", we_cnt, 1);
        repeat (3) @(negedge clk);
        chk("bp_no_duplicate_idle", {30'h0, dbg_state}, 32'h0);
        run_cmd("read_r11",  2'b10, 3'd0, 11, 0,  0,  32'h0,        32'h80000000, 0, 2, 0, 0);

        // Reset landing on WB of ADD R6=R4+R4 must cancel the write and the result.
        @(posedge clk);
        #1 drive_cmd(2'b01, 3'd0, 4, 4, 6, 32'h0);
        wait_accept("abort_add");
        @(posedge clk);
        #1;
        chk("abort_we_in_wb", {31'h0, we}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_we_gated", {31'h0, we}, 32'h0);
        chk("abort_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_state_idle", {30'h0, dbg_state}, 32'h0);
        chk("abort_no_result", {31'h0, res_valid}, 32'h0);
        chk("abort_rd_cleared", rd, 32'h0);
        run_cmd("read_r6_after_abort", 2'b10, 3'd0, 6, 0, 0, 32'h0, 32'h9, 0, 2, 0, 0);

        repeat (3) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
